// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if
//   Bundles the multiplexed 7-segment drive bus with the values recovered from it.
//   master : drives SEG_IN / AN_IN and reads the recovered results (the bus source).
//   slave  : the reader; samples SEG_IN / AN_IN and drives the results.
//   SEG_IN    [6:0]       active-low segments, bit0=a .. bit6=g
//   AN_IN     [NDIG-1:0]  active-low digit enables
//   HEX_OUT   [4*NDIG-1:0] decoded nibble per digit
//   DIG_VALID [NDIG-1:0]  last capture on that digit was a legal hex pattern
//   DIG_ERR   [NDIG-1:0]  last capture on that digit was unrecognised
//   FRAME_STB             one-cycle pulse when every digit has been captured
interface seg7_scan_reader_if #(
    parameter int NDIG = 4
);
    logic [6:0]        SEG_IN;
    logic [NDIG-1:0]   AN_IN;
    logic [4*NDIG-1:0] HEX_OUT;
    logic [NDIG-1:0]   DIG_VALID;
    logic [NDIG-1:0]   DIG_ERR;
    logic              FRAME_STB;

    modport master (
        output SEG_IN, AN_IN,
        input  HEX_OUT, DIG_VALID, DIG_ERR, FRAME_STB
    );

    modport slave (
        input  SEG_IN, AN_IN,
        output HEX_OUT, DIG_VALID, DIG_ERR, FRAME_STB
    );
endinterface

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//   Watches a multiplexed active-low 7-segment bus and recovers the hex digit
//   shown on each anode. The bus word {AN,SEG} is synchronised, and a capture is
//   taken once it has been steady for STABLE cycles. Each digit keeps its own
//   value / valid / error flags; FRAME_STB pulses when all digits have been seen.
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   bus   : seg7_scan_reader_if.slave (SEG_IN/AN_IN in, HEX_OUT/DIG_VALID/
//           DIG_ERR/FRAME_STB out; all outputs come straight from flops)
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    seg7_scan_reader_if.slave bus
);
    localparam int W  = NDIG + 7;
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

    typedef enum logic {
        SETTLE,
        HOLD
    } state_t;

    // Returns {legal, value}; legal=0 for anything outside the 16 hex glyphs.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h10;
            7'b1111001: r = 5'h11;
            7'b0100100: r = 5'h12;
            7'b0110000: r = 5'h13;
            7'b0011001: r = 5'h14;
            7'b0010010: r = 5'h15;
            7'b0000010: r = 5'h16;
            7'b1011000: r = 5'h17;
            7'b0000000: r = 5'h18;
            7'b0010000: r = 5'h19;
            7'b0001000: r = 5'h1A;
            7'b0000011: r = 5'h1B;
            7'b1000110: r = 5'h1C;
            7'b0100001: r = 5'h1D;
            7'b0000110: r = 5'h1E;
            7'b0001110: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Sync chain and previous-value register reset to all ones (display dark).
    logic [W-1:0]      sync1_q, sync2_q, prev_q;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] hex_q, hex_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              stb_q, stb_d;

    logic              change;
    logic              capture;
    logic [NDIG-1:0]   an_act;
    logic              an_onehot;
    logic [6:0]        seg_s;
    logic [4:0]        dec;
    logic [NDIG-1:0]   mask_nxt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        hex_d    = hex_q;
        valid_d  = valid_q;
        err_d    = err_q;
        stb_d    = 1'b0;
        capture  = 1'b0;
        mask_nxt = mask_q;

        change    = (sync2_q != prev_q);
        seg_s     = sync2_q[6:0];
        an_act    = ~sync2_q[W-1:7];
        // Exactly one anode low: non-zero and a power of two.
        an_onehot = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
        dec       = seg_decode(seg_s);

        case (state_q)
            SETTLE: begin
                if (change) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(STABLE - 1)) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (change) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
        endcase

        // Blank and illegal patterns leave the old nibble in place.
        if (capture && an_onehot) begin
            for (int i = 0; i < NDIG; i++) begin
                if (an_act[i]) begin
                    if (dec[4]) begin
                        hex_d[4*i +: 4] = dec[3:0];
                        valid_d[i]      = 1'b1;
                        err_d[i]        = 1'b0;
                    end else if (seg_s == 7'h7F) begin
                        valid_d[i] = 1'b0;
                        err_d[i]   = 1'b0;
                    end else begin
                        valid_d[i] = 1'b0;
                        err_d[i]   = 1'b1;
                    end
                end
            end
            mask_nxt = mask_q | an_act;
            if (&mask_nxt) begin
                stb_d  = 1'b1;
                mask_d = '0;
            end else begin
                mask_d = mask_nxt;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            state_q <= SETTLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            hex_q   <= '0;
            valid_q <= '0;
            err_q   <= '0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= {bus.AN_IN, bus.SEG_IN};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            stb_q   <= stb_d;
        end
    end

    assign bus.HEX_OUT   = hex_q;
    assign bus.DIG_VALID = valid_q;
    assign bus.DIG_ERR   = err_q;
    assign bus.FRAME_STB = stb_q;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader
//   Drives the scan bus of seg7_scan_reader (NDIG=4, STABLE=4) and compares the
//   recovered digits against a reference decoder held in the bench. Expected
//   digit state is queued when stimulus is applied and popped once the capture
//   window has elapsed.
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_reader_if #(.NDIG(NDIG)) bus ();

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [15:0] hex;
        logic [3:0]  valid;
        logic [3:0]  err;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference digit state
    logic [15:0] m_hex;
    logic [3:0]  m_valid, m_err;

    // Strobe monitor, sampled 1 time unit after each rising edge
    int          stb_cnt = 0;
    logic [15:0] stb_hex = '0;
    logic [15:0] stb_prev_hex = '0;
    logic [15:0] last_hex = '0;
    always @(posedge clk) begin
        #1;
        if (bus.FRAME_STB === 1'b1) begin
            stb_cnt++;
            stb_hex      = bus.HEX_OUT;
            stb_prev_hex = last_hex;
        end
        last_hex = bus.HEX_OUT;
    end

    task automatic model_reset();
        m_hex   = '0;
        m_valid = '0;
        m_err   = '0;
        sb.delete();
    endtask

    // Update the reference for a capture of (an, seg) and queue the result.
    task automatic model_capture(input string name, input logic [3:0] an, input logic [6:0] seg);
        exp_t e;
        int   lows = 0;
        int   d = 0;
        int   idx = -1;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin lows++; d = i; end
        if (lows == 1) begin
            for (int k = 0; k < 16; k++) if (pat[k] == seg) idx = k;
            if (idx >= 0) begin
                m_hex[4*d +: 4] = 4'(idx);
                m_valid[d] = 1'b1;
                m_err[d]   = 1'b0;
            end else if (seg == 7'h7F) begin
                m_valid[d] = 1'b0;
                m_err[d]   = 1'b0;
            end else begin
                m_valid[d] = 1'b0;
                m_err[d]   = 1'b1;
            end
        end
        e.name  = name;
        e.hex   = m_hex;
        e.valid = m_valid;
        e.err   = m_err;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        @(negedge clk);
        bus.AN_IN  = an;
        bus.SEG_IN = seg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.AN_IN  = '1;
        bus.SEG_IN = '1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.HEX_OUT !== 16'h0 || bus.DIG_VALID !== 4'h0 || bus.DIG_ERR !== 4'h0 || bus.FRAME_STB !== 1'b0) begin
            errors++;
            $display("FAIL reset: hex=%h valid=%b err=%b stb=%b, want 0", bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, bus.FRAME_STB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_capture();
        exp_t e;
        @(negedge clk);
        bus.AN_IN  = 4'b1110;
        bus.SEG_IN = 7'b0010010;
        model_capture("first", 4'b1110, 7'b0010010);
        repeat (STABLE + 2) @(posedge clk);
        #1;
        checks++;
        if (bus.HEX_OUT !== 16'h0 || bus.DIG_VALID !== 4'b0000) begin
            errors++;
            $display("FAIL early_capture: hex=%h valid=%b after %0d edges, want 0000/0000", bus.HEX_OUT, bus.DIG_VALID, STABLE + 2);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.HEX_OUT !== e.hex) begin
            errors++;
            $display("FAIL %s hex: got %h want %h", e.name, bus.HEX_OUT, e.hex);
        end
        checks++;
        if (bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
            errors++;
            $display("FAIL %s flags: valid=%b err=%b want %b/%b", e.name, bus.DIG_VALID, bus.DIG_ERR, e.valid, e.err);
        end
        checks++;
        if (bus.FRAME_STB !== 1'b0 || stb_cnt != 0) begin
            errors++;
            $display("FAIL first_stb: stb=%b count=%0d want 0", bus.FRAME_STB, stb_cnt);
        end
    endtask

    task automatic test_scan();
        exp_t       e;
        logic [6:0] segs [4] = '{7'b1111001, 7'b0100100, 7'b0110000, 7'b0001110};
        int         base = stb_cnt;
        for (int d = 0; d < 4; d++) begin
            logic [3:0] an = ~(4'b0001 << d);
            model_capture($sformatf("scan%0d", d), an, segs[d]);
            drive(an, segs[d], 10);
            e = sb.pop_front();
            checks++;
            if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
                errors++;
                $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                         e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
            end
        end
        checks++;
        if (stb_cnt != base + 1) begin
            errors++;
            $display("FAIL scan_stb_count: got %0d want %0d", stb_cnt - base, 1);
        end
        checks++;
        if (stb_hex !== 16'hF321 || stb_prev_hex[15:12] !== 4'h0) begin
            errors++;
            $display("FAIL scan_stb_align: hex at strobe=%h before=%h want F321 / digit3 0 before", stb_hex, stb_prev_hex);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        logic seen8 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.AN_IN  = 4'b1101;
            bus.SEG_IN = (k % 2 == 0) ? 7'b0000000 : 7'b0010000;
            repeat (2) begin
                @(posedge clk);
                #1;
                if (bus.HEX_OUT[7:4] == 4'h8) seen8 = 1'b1;
            end
        end
        model_capture("glitch_final", 4'b1101, 7'b0010000);
        // Two edges already elapsed since the final change.
        repeat (STABLE) @(posedge clk);
        #1;
        checks++;
        if (seen8 !== 1'b0 || bus.HEX_OUT[7:4] !== 4'h2) begin
            errors++;
            $display("FAIL glitch_nocap: seen8=%b digit1=%h want 0/2", seen8, bus.HEX_OUT[7:4]);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
            errors++;
            $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                     e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
        end
    endtask

    task automatic test_bad_and_blank();
        exp_t e;
        model_capture("bad_pattern", 4'b1011, 7'b1010101);
        drive(4'b1011, 7'b1010101, 10);
        e = sb.pop_front();
        checks++;
        if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
            errors++;
            $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                     e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
        end
        model_capture("blank", 4'b1011, 7'b1111111);
        drive(4'b1011, 7'b1111111, 10);
        e = sb.pop_front();
        checks++;
        if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
            errors++;
            $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                     e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
        end
    endtask

    task automatic test_ignored_anodes();
        exp_t e;
        int   base = stb_cnt;
        logic [3:0] ans [2] = '{4'b1111, 4'b1100};
        for (int j = 0; j < 2; j++) begin
            model_capture($sformatf("ignored_an_%b", ans[j]), ans[j], 7'b0000000);
            drive(ans[j], 7'b0000000, 10);
            e = sb.pop_front();
            checks++;
            if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
                errors++;
                $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                         e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
            end
        end
        checks++;
        if (stb_cnt != base) begin
            errors++;
            $display("FAIL ignored_stb: got %0d strobes want 0", stb_cnt - base);
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t       e;
        int         base = stb_cnt;
        logic [6:0] segs [3] = '{7'b0011001, 7'b0000010, 7'b0000000};
        for (int d = 0; d < 3; d++) begin
            logic [3:0] an = ~(4'b0001 << d);
            model_capture($sformatf("pre_reset%0d", d), an, segs[d]);
            drive(an, segs[d], 10);
            e = sb.pop_front();
            checks++;
            if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
                errors++;
                $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                         e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
            end
        end
        checks++;
        if (stb_cnt != base) begin
            errors++;
            $display("FAIL pre_reset_stb: got %0d strobes want 0", stb_cnt - base);
        end
        drive(4'b0111, 7'b1011000, 4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.HEX_OUT !== 16'h0 || bus.DIG_VALID !== 4'h0 || bus.DIG_ERR !== 4'h0 || bus.FRAME_STB !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: hex=%h valid=%b err=%b stb=%b want 0",
                     bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, bus.FRAME_STB);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_capture("post_reset3", 4'b0111, 7'b1011000);
        drive(4'b0111, 7'b1011000, 10);
        e = sb.pop_front();
        checks++;
        if (bus.HEX_OUT !== e.hex || bus.DIG_VALID !== e.valid || bus.DIG_ERR !== e.err) begin
            errors++;
            $display("FAIL %s: hex=%h valid=%b err=%b want %h/%b/%b",
                     e.name, bus.HEX_OUT, bus.DIG_VALID, bus.DIG_ERR, e.hex, e.valid, e.err);
        end
        checks++;
        if (stb_cnt != base) begin
            errors++;
            $display("FAIL post_reset_stb: got %0d strobes want 0", stb_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_first_capture();
        test_scan();
        test_glitch();
        test_bad_and_blank();
        test_ignored_anodes();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/seg7_scan_reader.md
Name: seg7_scan_reader

Overview:
- Monitors a multiplexed, active-low 7-segment drive bus (segment lines plus digit anodes) and recovers the hex value shown on each digit.
- It is the inverse of the team's hex-to-segment decoder and uses the same segment encoding.
- Used for loopback self-check of the clock display path and for capturing readings from external 7-seg drivers.
- Provides per-digit hex registers, validity and error flags, and a frame-complete strobe.

Parameters:
- NDIG, 4: number of multiplexed digits (anode lines).
- STABLE, 16: consecutive cycles {AN_IN,SEG_IN} must stay unchanged before a capture; must be ≥2.

Ports:
- CLK        input   1        system clock, rising edge.
- RST_N      input   1        asynchronous, active-low reset.
- SEG_IN     input   7        active-low segments, bit0=a … bit6=g.
- AN_IN      input   NDIG     active-low digit enables, one-hot-low when driving a digit.
- HEX_OUT    output  4*NDIG   decoded value; digit i occupies bits [4i+3:4i].
- DIG_VALID  output  NDIG     digit i last captured a legal hex pattern.
- DIG_ERR    output  NDIG     digit i last captured an unrecognised pattern.
- FRAME_STB  output  1        one-cycle pulse when every digit has been captured since the last strobe.

Behaviour:
- Reset (async, RST_N=0):
  - HEX_OUT=0, DIG_VALID=0, DIG_ERR=0, FRAME_STB=0.
  - Capture mask=0, stability counter=0, state=SETTLE.
  - Sync and previous-value registers all 1s (display dark).
  - Reset mid-frame discards the partial mask; no strobe is produced.
- Input sync: AN_IN and SEG_IN pass through 2-flop synchronisers. A previous-value register holds last cycle's synced word.
- Change detect: "change" = synced word differs from the previous-value register.
- State machine:
  - SETTLE: on change, cnt←0. Otherwise cnt increments. When cnt==STABLE-1 and no change, perform capture and go to HOLD.
  - HOLD: no further captures. On change, go to SETTLE with cnt←0.
- Capture, taken only if synced AN has exactly one bit low (digit i); all-high or multi-low AN is ignored, but the state machine still moves to HOLD.
  - Legal pattern (table below): HEX_OUT[i]←value, DIG_VALID[i]←1, DIG_ERR[i]←0.
  - 7'b1111111 (blank): HEX_OUT[i] held, DIG_VALID[i]←0, DIG_ERR[i]←0.
  - Any other pattern: HEX_OUT[i] held, DIG_VALID[i]←0, DIG_ERR[i]←1.
  - Every capture sets mask[i].
- Pattern table (SEG_IN[6:0] -> hex):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1011000->7.
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
- Latency: pins change and then stay stable; captured outputs are visible after exactly STABLE+3 rising edges (2 sync, 1 change detect, STABLE settle).
- Frame strobe:
  - When a capture makes the mask all-ones, FRAME_STB=1 on the same edge as that HEX update, and the mask clears to 0 on that edge.
  - Recapturing an already-marked digit does not strobe.
- Glitches: any change shorter than STABLE cycles restarts the count; no partial capture.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (NDIG=4, STABLE=4):
- Reset, then hold AN=1110, SEG=0010010 → after 7 edges HEX_OUT[3:0]=5, DIG_VALID=0001, DIG_ERR=0000, FRAME_STB=0.
- Scan digits 0..3 with patterns for 1,2,3,F, each held 10 cycles → HEX_OUT=16'hF321, DIG_VALID=1111, one FRAME_STB pulse coincident with the digit-3 update, mask cleared.
- AN=1101, SEG toggles 0000000/0010000 every 2 cycles for 20 cycles, then holds 0010000 → no capture during toggling; HEX_OUT[7:4]=9 exactly 7 edges after the final change.
- AN=1011, SEG=1010101 → DIG_ERR[2]=1, DIG_VALID[2]=0, HEX_OUT[11:8] unchanged. Then SEG=1111111 → both flags 0 for digit 2.
- AN=1111 and AN=1100 each held 10 cycles → no flag or HEX change, no strobe.
- Capture digits 0..2, assert RST_N=0 mid-way through digit 3 settling → all outputs 0 immediately. After release, scanning only digit 3 produces no FRAME_STB.
